// File: rtl/scan_rx_checker.sv
// Far-end checker for the walking-one pad-continuity scan: settles, decodes and sequence-checks patterns.
// Define SCAN_RX_TIMEOUT_EN to include the LOCKED-state stall timer (err_stall_o is tied 0 otherwise).
module scan_rx_checker #(
  parameter int N_PAIR  = 86,
  parameter int IDX_W   = 7,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 96
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              clr_i,
  input  logic [N_PAIR-1:0] scan_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              idx_valid_o,
  output logic              locked_o,
  output logic              err_onehot_o,
  output logic              err_seq_o,
  output logic              err_stall_o,
  output logic [15:0]       err_cnt_o,
  output logic              fail_o
);
  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED} state_t;

  if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1 || (2 ** IDX_W) < N_PAIR) begin : g_bad_cfg
    $error("scan_rx_checker: illegal parameter combination");
  end

  logic [N_PAIR-1:0] r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]  r_stab;
  state_t            r_state;
  logic [IDX_W-1:0]  r_idx, r_expect;
  logic              r_valid, r_locked, r_err_oh, r_err_seq, r_err_stall;
  logic [15:0]       r_err_cnt;
  logic              r_fail;

  logic              w_accept, w_onehot, w_live;
  logic [IDX_W-1:0]  w_idx, w_next;
  logic              w_err_oh, w_err_seq, w_stall_hit, w_err_any;

  // scan_i is asynchronous to clk; nothing may look at it before r_sync2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_stab  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge inputs, so the chain shifts by one.
      r_sync1 <= scan_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev)
        r_stab <= '0;
      else if (r_stab != CNT_W'(SETTLE))
        r_stab <= r_stab + CNT_W'(1);
    end
  end

  // Fires exactly once per stable run: the counter parks at SETTLE afterwards.
  assign w_accept = (r_sync2 == r_prev) && (r_stab == CNT_W'(SETTLE - 1));

  assign w_onehot = (r_sync2 != '0) && ((r_sync2 & (r_sync2 - N_PAIR'(1))) == '0);

  always_comb begin
    // NOTE: default assignment first, so no path through the block can infer a latch.
    w_idx = '0;
    for (int i = 0; i < N_PAIR; i++)
      if (r_sync2[i]) w_idx = w_idx | IDX_W'(i);
  end

  assign w_next = (w_idx == IDX_W'(N_PAIR - 1)) ? '0 : w_idx + IDX_W'(1);

  assign w_live    = enable_i && (r_state != S_IDLE);
  assign w_err_oh  = w_live && w_accept && !w_onehot;
  assign w_err_seq = w_live && w_accept && w_onehot && (r_state == S_LOCKED) && (w_idx != r_expect);

`ifdef SCAN_RX_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] r_stall_tmr;

  assign w_stall_hit = enable_i && (r_state == S_LOCKED) && !w_accept &&
                       (r_stall_tmr == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_tmr <= '0;
    else if (!enable_i || (r_state != S_LOCKED) || w_accept)
      r_stall_tmr <= '0;
    else if (!w_stall_hit)
      r_stall_tmr <= r_stall_tmr + TMR_W'(1);
  end
`else
  assign w_stall_hit = 1'b0;
`endif

  assign w_err_any = w_err_oh || w_err_seq || w_stall_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_expect    <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_err_oh    <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_stall <= 1'b0;
      r_err_cnt   <= '0;
      r_fail      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_err_oh    <= w_err_oh;
      r_err_seq   <= w_err_seq;
      r_err_stall <= w_stall_hit;

      if (!enable_i) begin
        r_state  <= S_IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_HUNT;
          S_HUNT: begin
            if (w_accept && w_onehot) begin
              r_idx    <= w_idx;
              r_valid  <= 1'b1;
              r_expect <= w_next;
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
            end
          end
          S_LOCKED: begin
            // A wrong but one-hot index resyncs in place; only a bad pattern or a stall drops lock.
            if (w_accept && w_onehot) begin
              r_idx    <= w_idx;
              r_valid  <= 1'b1;
              r_expect <= w_next;
            end else if (w_accept || w_stall_hit) begin
              r_state  <= S_HUNT;
              r_locked <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end

      if (clr_i) begin
        r_err_cnt <= '0;
        r_fail    <= 1'b0;
      end else if (w_err_any) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        r_fail <= 1'b1;
      end
    end
  end

  assign idx_o        = r_idx;
  assign idx_valid_o  = r_valid;
  assign locked_o     = r_locked;
  assign err_onehot_o = r_err_oh;
  assign err_seq_o    = r_err_seq;
  assign err_stall_o  = r_err_stall;
  assign err_cnt_o    = r_err_cnt;
  assign fail_o       = r_fail;

endmodule

// File: tb/tb_scan_rx_checker.sv
// Self-checking bench for scan_rx_checker: directed plan items plus randomized scan traffic against a behavioural model.
// Build with or without SCAN_RX_TIMEOUT_EN to match the RTL build.
module tb_scan_rx_checker;
  localparam int N_PAIR  = 86;
  localparam int IDX_W   = 7;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 96;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b1;
  logic              enable_i = 1'b0;
  logic              clr_i    = 1'b0;
  logic [N_PAIR-1:0] scan_i   = '0;
  logic [IDX_W-1:0]  idx_o;
  logic              idx_valid_o, locked_o, err_onehot_o, err_seq_o, err_stall_o, fail_o;
  logic [15:0]       err_cnt_o;

  int total = 0;
  int bad   = 0;

  scan_rx_checker #(.N_PAIR(N_PAIR), .IDX_W(IDX_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .clr_i(clr_i), .scan_i(scan_i),
    .idx_o(idx_o), .idx_valid_o(idx_valid_o), .locked_o(locked_o),
    .err_onehot_o(err_onehot_o), .err_seq_o(err_seq_o), .err_stall_o(err_stall_o),
    .err_cnt_o(err_cnt_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: s is the scan value two edges late; a pattern is accepted when
  // its run of identical s samples reaches SETTLE+1 (run is capped so it fires once).
  typedef struct packed {
    logic [N_PAIR-1:0] s1;
    logic [N_PAIR-1:0] s;
    logic [7:0]        run;
    logic [1:0]        mode;      // 0 idle, 1 hunt, 2 locked
    logic [IDX_W-1:0]  exp_idx;
    logic [15:0]       since_acc;
    logic [IDX_W-1:0]  idx;
    logic              valid, e_oh, e_seq, e_stall;
    logic [15:0]       cnt;
    logic              fail;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.run = 8'd2;
    return r;
  endfunction

  function automatic model_t model_next(model_t m, logic en, logic clr, logic [N_PAIR-1:0] scan, logic preload);
    model_t n;
    bit acc, onehot;
    int pos;
    n = m;
    acc    = (m.run == 8'(SETTLE + 1));
    onehot = ($countones(m.s) == 1);
    pos = 0;
    for (int i = 0; i < N_PAIR; i++) if (m.s[i]) pos = i;
    n.valid = 1'b0; n.e_oh = 1'b0; n.e_seq = 1'b0; n.e_stall = 1'b0;
    if (!en) n.mode = 2'd0;
    else if (m.mode == 2'd0) n.mode = 2'd1;
    else if (acc && !onehot) begin
      n.e_oh = 1'b1;
      n.mode = 2'd1;
    end else if (acc) begin
      if (m.mode == 2'd2 && IDX_W'(pos) != m.exp_idx) n.e_seq = 1'b1;
      n.idx       = IDX_W'(pos);
      n.valid     = 1'b1;
      n.exp_idx   = (pos == N_PAIR - 1) ? '0 : IDX_W'(pos + 1);
      n.mode      = 2'd2;
      n.since_acc = '0;
    end
`ifdef SCAN_RX_TIMEOUT_EN
    else if (m.mode == 2'd2) begin
      n.since_acc = m.since_acc + 16'd1;
      if (n.since_acc == 16'(TIMEOUT)) begin
        n.e_stall = 1'b1;
        n.mode    = 2'd1;
      end
    end
`endif
    if (preload) n.cnt = 16'hFFFE;
    else if (clr) begin
      n.cnt  = '0;
      n.fail = 1'b0;
    end else if (n.e_oh || n.e_seq || n.e_stall) begin
      if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
      n.fail = 1'b1;
    end
    n.run = (m.s1 == m.s) ? ((m.run >= 8'(SETTLE + 2)) ? m.run : m.run + 8'd1) : 8'd1;
    n.s   = m.s1;
    n.s1  = scan;
    return n;
  endfunction

  model_t m;
  logic   preload_req = 1'b0;
  logic   cmp_on      = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_next(m, enable_i, clr_i, scan_i, preload_req);
  end

  always @(negedge clk) begin
    if (reset_n && cmp_on) begin
      check("idx_o",        32'(idx_o),        32'(m.idx));
      check("idx_valid_o",  32'(idx_valid_o),  32'(m.valid));
      check("locked_o",     32'(locked_o),     32'(m.mode == 2'd2));
      check("err_onehot_o", 32'(err_onehot_o), 32'(m.e_oh));
      check("err_seq_o",    32'(err_seq_o),    32'(m.e_seq));
      check("err_stall_o",  32'(err_stall_o),  32'(m.e_stall));
      check("err_cnt_o",    32'(err_cnt_o),    32'(m.cnt));
      check("fail_o",       32'(fail_o),       32'(m.fail));
    end
  end

  // Pulse tallies of the DUT, used against hand-computed literals in the directed part.
  int cyc = 0;
  int n_valid = 0, n_seq = 0, n_oh = 0, n_stall = 0;
  int last_valid_cyc = 0, stall_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (reset_n) begin
      if (idx_valid_o === 1'b1) begin
        n_valid        <= n_valid + 1;
        last_valid_cyc <= cyc;
      end
      if (err_seq_o === 1'b1)    n_seq <= n_seq + 1;
      if (err_onehot_o === 1'b1) n_oh  <= n_oh + 1;
      if (err_stall_o === 1'b1) begin
        n_stall   <= n_stall + 1;
        stall_cyc <= cyc;
      end
    end
  end

  function automatic logic [N_PAIR-1:0] oh(input int i);
    logic [N_PAIR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Caller sits just after a falling edge; pattern is held for 'cycles' falling edges.
  task automatic apply(input logic [N_PAIR-1:0] pat, input int cycles);
    scan_i = pat;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  function automatic int nxt(input int i);
    return (i == N_PAIR - 1) ? 0 : i + 1;
  endfunction

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v, base_s, base_o, base_st, cur;
    logic [95:0] wide;
    logic [N_PAIR-1:0] pat;

    #1 reset_n = 1'b0;
    enable_i = 1'b1;
    scan_i   = oh(0);
    #3;
    check("rst idx_o", 32'(idx_o), 32'd0);
    check("rst idx_valid_o", 32'(idx_valid_o), 32'd0);
    check("rst locked_o", 32'(locked_o), 32'd0);
    check("rst err_onehot_o", 32'(err_onehot_o), 32'd0);
    check("rst err_seq_o", 32'(err_seq_o), 32'd0);
    check("rst err_stall_o", 32'(err_stall_o), 32'd0);
    check("rst err_cnt_o", 32'(err_cnt_o), 32'd0);
    check("rst fail_o", 32'(fail_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cmp_on  = 1'b1;
    #1;

    // Full walk 0..85 then wrap to 0.
    for (int i = 0; i < N_PAIR; i++) begin
      apply(oh(i), 32);
      if (i == N_PAIR - 1) check("walk idx before wrap", 32'(idx_o), 32'd85);
    end
    apply(oh(0), 32);
    check("walk valid count", 32'(n_valid), 32'd87);
    check("walk wrap idx", 32'(idx_o), 32'd0);
    check("walk locked", 32'(locked_o), 32'd1);
    check("walk err_cnt", 32'(err_cnt_o), 32'd0);
    check("walk fail", 32'(fail_o), 32'd0);

    // Skip index 10.
    base_s = n_seq;
    for (int i = 1; i <= 9; i++) apply(oh(i), 32);
    apply(oh(11), 32);
    check("skip idx", 32'(idx_o), 32'd11);
    check("skip err_cnt", 32'(err_cnt_o), 32'd1);
    check("skip fail", 32'(fail_o), 32'd1);
    check("skip seq pulses", 32'(n_seq - base_s), 32'd1);
    apply(oh(12), 32);
    check("after skip idx", 32'(idx_o), 32'd12);
    check("after skip err_cnt", 32'(err_cnt_o), 32'd1);
    check("after skip locked", 32'(locked_o), 32'd1);

    // Clear, then a two-hot pattern drops lock; next one-hot relocks.
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    #1;
    check("clr err_cnt", 32'(err_cnt_o), 32'd0);
    check("clr fail", 32'(fail_o), 32'd0);
    base_o = n_oh;
    apply(oh(5) | oh(6), 32);
    check("multihot locked", 32'(locked_o), 32'd0);
    check("multihot err_cnt", 32'(err_cnt_o), 32'd1);
    check("multihot pulses", 32'(n_oh - base_o), 32'd1);
    apply(oh(13), 32);
    check("relock locked", 32'(locked_o), 32'd1);
    check("relock idx", 32'(idx_o), 32'd13);

    // One-cycle glitch inside a step, before it settles.
    base_v = n_valid;
    apply(oh(14), 2);
    apply(oh(40), 1);
    apply(oh(14), 29);
    check("glitch valid pulses", 32'(n_valid - base_v), 32'd1);
    check("glitch idx", 32'(idx_o), 32'd14);
    check("glitch err_cnt", 32'(err_cnt_o), 32'd1);

    // Frozen pattern after lock.
    base_st = n_stall;
    apply(oh(14), 200);
`ifdef SCAN_RX_TIMEOUT_EN
    check("stall pulses", 32'(n_stall - base_st), 32'd1);
    check("stall delay", 32'(stall_cyc - last_valid_cyc), 32'(TIMEOUT));
    check("stall locked", 32'(locked_o), 32'd0);
`else
    check("no stall pulses", 32'(n_stall - base_st), 32'd0);
    check("no stall locked", 32'(locked_o), 32'd1);
`endif
    apply(oh(15), 32);
    check("post freeze locked", 32'(locked_o), 32'd1);
    check("post freeze idx", 32'(idx_o), 32'd15);

    // Error counter saturation from a preloaded value.
    force dut.r_err_cnt = 16'hFFFE;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    release dut.r_err_cnt;
    #1;
    check("preload err_cnt", 32'(err_cnt_o), 32'hFFFE);
    apply(oh(1) | oh(2), 32);
    apply(oh(3) | oh(4), 32);
    apply(oh(7) | oh(8), 32);
    check("saturate err_cnt", 32'(err_cnt_o), 32'hFFFF);
    check("saturate fail", 32'(fail_o), 32'd1);

    // clr_i on the very edge that registers an all-zero pattern error.
    scan_i = '0;
    repeat (6) @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    #1;
    check("clr+err pulse", 32'(err_onehot_o), 32'd1);
    check("clr+err err_cnt", 32'(err_cnt_o), 32'd0);
    check("clr+err fail", 32'(fail_o), 32'd0);

    // Randomized traffic; the model comparison runs on every cycle.
    cur = 0;
    for (int it = 0; it < 700; it++) begin
      int r, len;
      r   = $urandom_range(0, 99);
      len = $urandom_range(1, 40);
      if (it == 350) begin
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
      end
      if (r < 70) begin
        cur = nxt(cur);
        apply(oh(cur), len);
      end else if (r < 78) begin
        cur = $urandom_range(0, N_PAIR - 1);
        apply(oh(cur), len);
      end else if (r < 86) begin
        wide = {$urandom(), $urandom(), $urandom()};
        pat  = (r < 80) ? '0 : wide[N_PAIR-1:0];
        apply(pat, len);
      end else if (r < 91) begin
        cur = nxt(cur);
        apply(oh(cur), $urandom_range(1, 4));
        apply(oh($urandom_range(0, N_PAIR - 1)), 1);
        apply(oh(cur), len);
      end else if (r < 95) begin
        enable_i = 1'b0;
        apply(oh(cur), $urandom_range(1, 8));
        enable_i = 1'b1;
        cur = nxt(cur);
        apply(oh(cur), len);
      end else if (r < 98) begin
        cur = nxt(cur);
        scan_i = oh(cur);
        repeat ($urandom_range(0, 8)) @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        apply(oh(cur), len);
      end else begin
        cur = nxt(cur);
        apply(oh(cur), 130);
      end
    end

    repeat (10) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
